// File: rtl/write_out_ctrl.sv
// Output write-path sequencer for the systolic array.
// Walks every output diagonal of each tile after the array fill latency.
module write_out_ctrl #(
   parameter int ARRAY_SIZE   = 8,
   parameter int FILL_LATENCY = 9,
   parameter int SET_WIDTH    = 10
) (
   input  logic                 clk,
   input  logic                 srstn,
   input  logic                 start,
   input  logic [SET_WIDTH-1:0] num_sets,
   input  logic                 stall,
   input  logic                 abort,
   output logic                 sram_write_enable,
   output logic [SET_WIDTH-1:0] data_set,
   output logic [5:0]           matrix_index,
   output logic                 busy,
   output logic                 done
);

   localparam logic [5:0] LAST_IDX = 6'(2 * ARRAY_SIZE - 2);
   localparam logic [5:0] FILL_CNT = 6'(FILL_LATENCY);
   localparam logic [SET_WIDTH-1:0] ONE = SET_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } state_t;

   state_t               state_q;
   logic [5:0]           cnt_q;
   logic [SET_WIDTH-1:0] nsets_q;
   logic                 we_q;
   logic [SET_WIDTH-1:0] set_q;
   logic [5:0]           idx_q;
   logic                 busy_q;
   logic                 done_q;

   // we_q marks that idx_q is being written this cycle; stall sampled at
   // the edge decides whether the next cycle carries a write.
   always_ff @(posedge clk) begin
      if (!srstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         nsets_q <= '0;
         we_q    <= 1'b0;
         set_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (abort && state_q != IDLE) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         set_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               we_q   <= 1'b0;
               done_q <= 1'b0;
               if (start) begin
                  if (num_sets == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= FILL;
                     nsets_q <= num_sets;
                     set_q   <= '0;
                     idx_q   <= '0;
                     cnt_q   <= FILL_CNT;
                     busy_q  <= 1'b1;
                  end
               end
            end
            FILL: begin
               cnt_q <= cnt_q - 6'd1;
               we_q  <= 1'b0;
               if (cnt_q == 6'd1) begin
                  state_q <= WRITE;
                  idx_q   <= '0;
                  we_q    <= !stall;
               end
            end
            WRITE: begin
               if (we_q && idx_q == LAST_IDX) begin
                  we_q <= 1'b0;
                  if (set_q == nsets_q - ONE) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= FILL;
                     set_q   <= set_q + ONE;
                     idx_q   <= '0;
                     cnt_q   <= FILL_CNT;
                  end
               end else begin
                  if (we_q) idx_q <= idx_q + 6'd1;
                  we_q <= !stall;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               we_q    <= 1'b0;
               set_q   <= '0;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign sram_write_enable = we_q;
   assign data_set          = set_q;
   assign matrix_index      = idx_q;
   assign busy              = busy_q;
   assign done              = done_q;

endmodule
